// File: rtl/fifo_serializer_pkg.sv
// Shared types and helpers for the FIFO word-to-beat serializer.
package fifo_ser_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        SEND = 2'd2
    } ser_state_t;

    function automatic int beats_per_word(input int in_w, input int out_w);
        return in_w / out_w;
    endfunction

endpackage

// File: rtl/fifo_serializer.sv
// Pops whole FIFO words and replays them as OUT_WIDTH beats, LSB slice first.
// Optional build macro FIFO_SER_STATS_EN adds word_cnt / stall_cnt outputs.
module fifo_serializer
    import fifo_ser_pkg::*;
#(
    parameter int IN_WIDTH  = 128,
    parameter int OUT_WIDTH = 32
) (
    input  logic                 clk_if,
    input  logic                 arst,
    input  logic                 ff_mty,
    input  logic [IN_WIDTH-1:0]  ff_q,
    output logic                 ff_rd,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_first,
    output logic                 out_last,
    output logic                 busy
`ifdef FIFO_SER_STATS_EN
    ,
    output logic [31:0]          word_cnt,
    output logic [31:0]          stall_cnt
`endif
);

    localparam int RATIO = beats_per_word(IN_WIDTH, OUT_WIDTH);
    localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

    if (IN_WIDTH % OUT_WIDTH != 0) begin : g_bad_width
        $error("fifo_serializer: IN_WIDTH must be a multiple of OUT_WIDTH");
    end
    if (RATIO < 2) begin : g_bad_ratio
        $error("fifo_serializer: IN_WIDTH/OUT_WIDTH must be at least 2");
    end

    ser_state_t           state_q, state_d;
    logic [IN_WIDTH-1:0]  word_q, word_d;
    logic [IDX_W-1:0]     beat_idx_q, beat_idx_d;
    logic [OUT_WIDTH-1:0] out_data_q, out_data_d;
    logic                 out_valid_q, out_valid_d;
    logic                 out_first_q, out_first_d;
    logic                 out_last_q, out_last_d;
    logic                 busy_q, busy_d;
    logic                 accept;
    logic                 pop;
    int unsigned          lsb;

    assign accept = out_valid_q && out_ready;

    always_comb begin
        state_d    = state_q;
        word_d     = word_q;
        beat_idx_d = beat_idx_q;
        pop        = 1'b0;

        case (state_q)
            IDLE: begin
                if (!ff_mty) begin
                    pop     = 1'b1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                word_d     = ff_q;
                beat_idx_d = '0;
                state_d    = SEND;
            end
            SEND: begin
                if (accept) begin
                    if (beat_idx_q != LAST_IDX) begin
                        beat_idx_d = beat_idx_q + IDX_W'(1);
                    end else begin
                        beat_idx_d = '0;
                        // Back-to-back words: the next pop overlaps the last beat.
                        if (!ff_mty) begin
                            pop     = 1'b1;
                            state_d = WAIT;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered, so they are derived from the next state.
        lsb         = int'(beat_idx_d) * OUT_WIDTH;
        out_valid_d = (state_d == SEND);
        out_first_d = (state_d == SEND) && (beat_idx_d == '0);
        out_last_d  = (state_d == SEND) && (beat_idx_d == LAST_IDX);
        out_data_d  = '0;
        if (state_d == SEND) begin
            out_data_d = word_d[lsb +: OUT_WIDTH];
        end
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk_if) begin
        if (arst) begin
            state_q     <= IDLE;
            word_q      <= '0;
            beat_idx_q  <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_first_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            word_q      <= word_d;
            beat_idx_q  <= beat_idx_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_first_q <= out_first_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
        end
    end

    // The pop strobe is combinational so the FIFO sees it in the decision cycle.
    assign ff_rd     = pop && !arst;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_first = out_first_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;

`ifdef FIFO_SER_STATS_EN
    logic [31:0] word_cnt_q, word_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        word_cnt_d  = word_cnt_q + {31'd0, accept && out_last_q};
        stall_cnt_d = stall_cnt_q + {31'd0, out_valid_q && !out_ready};
    end

    always_ff @(posedge clk_if) begin
        if (arst) begin
            word_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            word_cnt_q  <= word_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign word_cnt  = word_cnt_q;
    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_serializer.sv
// Scoreboard bench for fifo_serializer: queued FIFO model, beat reference queue, protocol monitor.
module tb_fifo_serializer;

    localparam int IN_W  = 128;
    localparam int OUT_W = 32;
    localparam int RATIO = IN_W / OUT_W;

    logic              clk_if    = 1'b0;
    logic              arst      = 1'b1;
    logic              ff_mty    = 1'b1;
    logic [IN_W-1:0]   ff_q      = '0;
    logic              ff_rd;
    logic [OUT_W-1:0]  out_data;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic              out_first;
    logic              out_last;
    logic              busy;
`ifdef FIFO_SER_STATS_EN
    logic [31:0]       word_cnt;
    logic [31:0]       stall_cnt;
`endif

    fifo_serializer #(.IN_WIDTH(IN_W), .OUT_WIDTH(OUT_W)) dut (
        .clk_if    (clk_if),
        .arst      (arst),
        .ff_mty    (ff_mty),
        .ff_q      (ff_q),
        .ff_rd     (ff_rd),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_first (out_first),
        .out_last  (out_last),
        .busy      (busy)
`ifdef FIFO_SER_STATS_EN
        ,
        .word_cnt  (word_cnt),
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 clk_if = ~clk_if;

    typedef struct {
        logic [OUT_W-1:0] data;
        int               idx;
    } beat_t;

    int              checks   = 0;
    int              failures = 0;
    int              cyc      = 0;
    int              rd_total = 0;
    int              stall_seen = 0;
    beat_t           exp_q[$];
    logic [IN_W-1:0] fifo[$];

    function automatic void check(input bit ok, input string name,
                                  input logic [IN_W-1:0] act, input logic [IN_W-1:0] req);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
        end
    endfunction

    // Reference model: a word entering the FIFO yields RATIO beats, low slice first.
    function automatic void push_word(input logic [IN_W-1:0] w);
        beat_t b;
        fifo.push_back(w);
        for (int i = 0; i < RATIO; i++) begin
            b.data = w[i*OUT_W +: OUT_W];
            b.idx  = i;
            exp_q.push_back(b);
        end
        $display("push word=0x%032h", w);
    endfunction

    function automatic logic [IN_W-1:0] rand_word();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // FIFO model: registered read data and registered empty flag.
    always @(posedge clk_if) begin
        cyc <= cyc + 1;
        if (ff_rd && fifo.size() > 0) begin
            ff_q <= fifo.pop_front();
        end
        ff_mty <= (fifo.size() == 0);
    end

    // Monitor: beat scoreboard, stall stability and pop-strobe protocol.
    logic             prev_stall = 1'b0;
    logic             prev_rd    = 1'b0;
    logic [OUT_W+1:0] prev_beat  = '0;
    always @(negedge clk_if) begin
        if (arst) begin
            if (ff_rd) check(1'b0, "rd_in_reset", IN_W'(ff_rd), '0);
            prev_stall = 1'b0;
            prev_rd    = 1'b0;
        end else begin
            if (ff_rd) begin
                rd_total++;
                check(!ff_mty && !prev_rd &&
                      !(out_valid && !(out_ready && out_last)),
                      "rd_protocol", IN_W'({ff_mty, prev_rd, out_valid, out_ready, out_last}),
                      IN_W'(5'b00011));
            end
            if (prev_stall) begin
                check(out_valid && {out_first, out_last, out_data} == prev_beat,
                      "stall_hold", IN_W'({out_valid, out_first, out_last, out_data}),
                      IN_W'({1'b1, prev_beat}));
            end
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check(1'b0, "unexpected_beat", IN_W'(out_data), '0);
                end else begin
                    check(out_data == exp_q[0].data &&
                          out_first == (exp_q[0].idx == 0) &&
                          out_last == (exp_q[0].idx == RATIO - 1),
                          "beat", IN_W'({out_first, out_last, out_data}),
                          IN_W'({exp_q[0].idx == 0, exp_q[0].idx == RATIO - 1, exp_q[0].data}));
                    if (out_ready) begin
                        $display("beat data=0x%08h first=%0b last=%0b", out_data, out_first, out_last);
                        void'(exp_q.pop_front());
                    end else begin
                        stall_seen++;
                    end
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_beat  = {out_first, out_last, out_data};
            prev_rd    = ff_rd;
        end
    end

    task automatic tick();
        @(posedge clk_if);
        #1;
    endtask

    task automatic pulse_reset();
        tick();
        arst = 1'b1;
        tick();
        arst = 1'b0;
    endtask

    task automatic drain();
        bit done = 1'b0;
        out_ready = 1'b1;
        for (int n = 0; n < 2000 && !done; n++) begin
            @(negedge clk_if);
            done = (exp_q.size() == 0) && (fifo.size() == 0) && !busy;
        end
        check(done, "drain_timeout", IN_W'(exp_q.size()), '0);
        tick();
    endtask

    logic [IN_W-1:0] w0;
    initial begin
        int  c0, c1, rd0, st0, n_hs;
        bit  found, bad;

        w0 = 128'h0F0E0D0C_0B0A0908_07060504_03020100;

        // Reset values, then a word waiting in the FIFO while reset is held.
        repeat (2) tick();
        @(negedge clk_if);
        check(!out_valid && out_data == '0 && !out_first && !out_last && !busy && !ff_rd,
              "reset_state", IN_W'({out_valid, out_first, out_last, busy, ff_rd, out_data}), '0);
`ifdef FIFO_SER_STATS_EN
        check(word_cnt == 0 && stall_cnt == 0, "reset_stats",
              IN_W'({word_cnt, stall_cnt}), '0);
`endif
        tick();
        out_ready = 1'b1;
        push_word(w0);
        repeat (3) tick();

        // Single word: two-cycle latency from the pop, exactly one pop.
        rd0 = rd_total;
        arst = 1'b0;
        found = 1'b0;
        for (int n = 0; n < 20 && !found; n++) begin
            @(negedge clk_if);
            if (ff_rd) found = 1'b1;
        end
        c0 = cyc;
        check(found, "first_rd_seen", IN_W'(found), 1);
        found = 1'b0;
        for (int n = 0; n < 20 && !found; n++) begin
            @(negedge clk_if);
            if (out_valid) found = 1'b1;
        end
        c1 = cyc;
        check(found && c1 - c0 == 2, "first_beat_latency", IN_W'(c1 - c0), 2);
        drain();
        check(rd_total - rd0 == 1, "single_word_pops", IN_W'(rd_total - rd0), 1);

        // Three queued words: 12 beats over 15 cycles after the first pop.
        rd0 = rd_total;
        for (int i = 0; i < 3; i++) push_word(rand_word());
        found = 1'b0;
        for (int n = 0; n < 20 && !found; n++) begin
            @(negedge clk_if);
            if (ff_rd) found = 1'b1;
        end
        c0 = cyc;
        n_hs = 0;
        c1 = c0;
        for (int n = 0; n < 40 && n_hs < 3 * RATIO; n++) begin
            @(negedge clk_if);
            if (out_valid && out_ready) begin
                n_hs++;
                c1 = cyc;
            end
        end
        check(n_hs == 3 * RATIO && c1 - c0 == 15, "three_word_cycles",
              IN_W'(c1 - c0), 15);
        drain();
        check(rd_total - rd0 == 3, "three_word_pops", IN_W'(rd_total - rd0), 3);
        @(negedge clk_if);
        check(!busy && !out_valid, "back_to_idle", IN_W'({busy, out_valid}), '0);

        // Five-cycle stall on the second beat.
        pulse_reset();
        push_word(w0);
        found = 1'b0;
        for (int n = 0; n < 20 && !found; n++) begin
            @(negedge clk_if);
            if (out_valid && out_first) found = 1'b1;
        end
        check(found, "stall_first_seen", IN_W'(found), 1);
        tick();
        out_ready = 1'b0;
        st0 = stall_seen;
        repeat (5) @(posedge clk_if);
        #1;
        out_ready = 1'b1;
        drain();
        check(stall_seen - st0 == 5, "stall_cycles", IN_W'(stall_seen - st0), 5);
`ifdef FIFO_SER_STATS_EN
        check(stall_cnt == 5, "stall_cnt", IN_W'(stall_cnt), 5);
`endif

        // Empty FIFO: nothing happens.
        bad = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk_if);
            if (ff_rd || out_valid || busy) bad = 1'b1;
        end
        check(!bad, "empty_idle", IN_W'(bad), 0);

        // Reset while the third beat is presented: the partial word is dropped.
        rd0 = rd_total;
        push_word(rand_word());
        push_word(rand_word());
        found = 1'b0;
        for (int n = 0; n < 20 && !found; n++) begin
            @(negedge clk_if);
            if (out_valid && exp_q.size() > 0 && exp_q[0].idx == 1) found = 1'b1;
        end
        check(found, "reset_beat_seen", IN_W'(found), 1);
        tick();
        arst = 1'b1;
        tick();
        arst = 1'b0;
        while (exp_q.size() > 0 && exp_q[0].idx != 0) void'(exp_q.pop_front());
        @(negedge clk_if);
        check(!out_valid && !busy, "after_mid_reset", IN_W'({out_valid, busy}), '0);
        drain();
        check(rd_total - rd0 == 2, "mid_reset_pops", IN_W'(rd_total - rd0), 2);

`ifdef FIFO_SER_STATS_EN
        pulse_reset();
        for (int i = 0; i < 4; i++) push_word(rand_word());
        drain();
        check(word_cnt == 4, "word_cnt", IN_W'(word_cnt), 4);
        pulse_reset();
        @(negedge clk_if);
        check(word_cnt == 0, "word_cnt_reset", IN_W'(word_cnt), 0);
`endif

        // Random traffic with random back-pressure.
        for (int n = 0; n < 400; n++) begin
            tick();
            if ($urandom_range(0, 3) == 0 && fifo.size() < 3) push_word(rand_word());
            out_ready = ($urandom_range(0, 3) != 0);
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        failures++;
        $display("FAIL watchdog: actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
